// File: rtl/ram_scan_pkg.sv
// Shared FSM state encoding and parameter defaults for the RAM scan controller.
package ram_scan_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 5;
  localparam int TICK_DIV_DEF = 50000000;

endpackage

// File: rtl/tick_divider.sv
// Counts 0..TICK_DIV-1 while enabled; o_wrap flags the wrap cycle, o_step is its registered pulse.
module tick_divider
  import ram_scan_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  output logic o_wrap,
  output logic o_step
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == CNT_W'(TICK_DIV - 1));

  // Dropping the enable zeroes the count, so every scan period starts fresh.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      o_step <= 1'b0;
    end else begin
      o_step <= o_wrap;
      if (!i_en || o_wrap) r_cnt <= '0;
      else                 r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ram_scan_ctrl.sv
// Single-port RAM with manual, auto-scan and (RAM_SCAN_CLEAR_EN) clear-sweep modes.
// Address/data pass one input stage; write and registered read happen on the following edge (read-first).
module ram_scan_ctrl
  import ram_scan_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scan_en,
  input  logic [ADDR_W-1:0] manual_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              clear_req,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              step,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            r_state;
  logic [ADDR_W-1:0] r_scan_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wen;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_addr_src;
  logic [DATA_W-1:0] w_wdata_src;
  logic              w_wen_src;
  logic              w_clr_go;
  logic              w_stay_scan;
  logic              w_tick;

`ifdef RAM_SCAN_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_busy;

  assign w_clr_go = clear_req && (r_state != ST_CLEAR);
  assign busy     = r_busy;
`else
  logic w_unused_clear;

  assign w_unused_clear = clear_req;
  assign w_clr_go       = 1'b0;
  assign busy           = 1'b0;
`endif

  // The tick only runs on cycles that stay in SCAN, so no step leaks out on the exit edge.
  assign w_stay_scan = (r_state == ST_SCAN) && scan_en && !w_clr_go;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .i_en  (w_stay_scan),
    .o_wrap(w_tick),
    .o_step(step)
  );

  always_comb begin
    w_addr_src  = manual_addr;
    w_wdata_src = wr_data;
    w_wen_src   = wr_en && (r_state == ST_MANUAL);
    if (r_state == ST_SCAN) begin
      w_addr_src = r_scan_addr;
    end
`ifdef RAM_SCAN_CLEAR_EN
    if (r_state == ST_CLEAR) begin
      w_addr_src  = r_clr_addr;
      w_wdata_src = '0;
      w_wen_src   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_MANUAL;
      r_scan_addr <= '0;
`ifdef RAM_SCAN_CLEAR_EN
      r_clr_addr  <= '0;
      r_busy      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_MANUAL: begin
          if (w_clr_go) begin
            r_state <= ST_CLEAR;
`ifdef RAM_SCAN_CLEAR_EN
            r_busy  <= 1'b1;
`endif
          end else if (scan_en) begin
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_tick) r_scan_addr <= r_scan_addr + ADDR_W'(1);
          if (w_clr_go) begin
            r_state <= ST_CLEAR;
`ifdef RAM_SCAN_CLEAR_EN
            r_busy  <= 1'b1;
`endif
          end else if (!scan_en) begin
            r_state <= ST_MANUAL;
          end
        end
`ifdef RAM_SCAN_CLEAR_EN
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + ADDR_W'(1);
          if (r_clr_addr == '1) begin
            r_state     <= scan_en ? ST_SCAN : ST_MANUAL;
            r_busy      <= 1'b0;
            r_scan_addr <= '0;
          end
        end
`endif
        default: r_state <= ST_MANUAL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_addr <= '0;
      r_wdata  <= '0;
      r_wen    <= 1'b0;
      rd_data  <= '0;
    end else begin
      cur_addr <= w_addr_src;
      r_wdata  <= w_wdata_src;
      r_wen    <= w_wen_src;
      rd_data  <= r_mem[cur_addr];
    end
  end

  // Memory is deliberately outside the reset domain so a reset keeps its contents.
  always_ff @(posedge clock) begin
    if (r_wen) r_mem[cur_addr] <= r_wdata;
  end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Directed/randomized bench for ram_scan_ctrl (DATA_W=8, ADDR_W=5, TICK_DIV=4) against a memory-array model.
module tb_ram_scan_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int TD    = 4;
  localparam int DEPTH = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          scan_en;
  logic [AW-1:0] manual_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          clear_req;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] cur_addr;
  logic          step;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  int            s_scan;

  ram_scan_ctrl #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .TICK_DIV(TD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .scan_en    (scan_en),
    .manual_addr(manual_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .clear_req  (clear_req),
    .rd_data    (rd_data),
    .cur_addr   (cur_addr),
    .step       (step),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pipelined sweep: address j presented at one negedge, its data visible two negedges later.
  task automatic read_all_check(input string tag);
    for (int j = 0; j < DEPTH + 2; j++) begin
      if (j >= 2) chk(tag, {24'd0, rd_data}, {24'd0, ref_mem[j-2]});
      if (j < DEPTH) manual_addr = AW'(j);
      @(negedge clock);
    end
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    manual_addr = AW'(a);
    wr_data     = d;
    wr_en       = 1'b1;
    ref_mem[a]  = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input int a);
    manual_addr = AW'(a);
    wr_en       = 1'b0;
    @(negedge clock);
    chk({tag, "_addr"}, {27'd0, cur_addr}, a);
    @(negedge clock);
    chk({tag, "_data"}, {24'd0, rd_data}, {24'd0, ref_mem[a]});
  endtask

  // Scan for K edges after entry while hammering writes that must be ignored.
  task automatic scan_run(input string tag, input int k_len);
    scan_en = 1'b1;
    @(negedge clock);
    wr_en       = 1'b1;
    wr_data     = 8'hFF;
    manual_addr = AW'($urandom_range(0, DEPTH - 1));
    for (int k = 1; k <= k_len; k++) begin
      @(negedge clock);
      chk({tag, "_addr"}, {27'd0, cur_addr}, (s_scan + (k - 1) / TD) % DEPTH);
      chk({tag, "_step"}, {31'd0, step}, ((k % TD) == 0) ? 1 : 0);
    end
    scan_en = 1'b0;
    wr_en   = 1'b0;
    s_scan  = (s_scan + k_len / TD) % DEPTH;
    @(negedge clock);
    chk({tag, "_step_exit"}, {31'd0, step}, 0);
    @(negedge clock);
    chk({tag, "_step_manual"}, {31'd0, step}, 0);
  endtask

  initial begin
    int k;
    int n;
    int hit;
    logic [DW-1:0] old_word;

    reset       = 1'b0;
    scan_en     = 1'b0;
    manual_addr = '0;
    wr_data     = '0;
    wr_en       = 1'b0;
    clear_req   = 1'b0;
    s_scan      = 0;

    @(negedge clock);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    chk("rst_cur_addr", {27'd0, cur_addr}, 0);
    chk("rst_step", {31'd0, step}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < DEPTH; i++) do_write(i, DW'($urandom));
    do_write(7, 8'h11);
    @(negedge clock);
    read_all_check("fill");

    do_write(3, 8'hA5);
    do_read("man_a5", 3);
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(0, DEPTH - 1);
      do_write(n, DW'($urandom));
      do_read("man_rand", n);
    end

    // Read-during-write on address 7: old word first, new word one cycle later.
    do_write(7, 8'h11);
    @(negedge clock);
    @(negedge clock);
    old_word    = ref_mem[7];
    manual_addr = AW'(7);
    wr_data     = 8'h22;
    wr_en       = 1'b1;
    @(negedge clock);
    wr_en      = 1'b0;
    ref_mem[7] = 8'h22;
    @(negedge clock);
    chk("rdw_old", {24'd0, rd_data}, {24'd0, old_word});
    @(negedge clock);
    chk("rdw_new", {24'd0, rd_data}, 32'h22);

    scan_run("scan_full", 4 * DEPTH + 4);
    read_all_check("scan_nowrite");
    scan_run("scan_part", $urandom_range(5, 15));
    scan_run("scan_reenter", $urandom_range(8, 12));

    // Reset mid-scan once cur_addr reaches 9.
    scan_en = 1'b1;
    @(negedge clock);
    hit = 0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clock);
      chk("rstscan_addr", {27'd0, cur_addr}, (s_scan + (k - 1) / TD) % DEPTH);
      if (((s_scan + (k - 1) / TD) % DEPTH) == 9) begin
        hit = 1;
        break;
      end
    end
    chk("rstscan_reached9", hit, 1);
    reset   = 1'b0;
    scan_en = 1'b0;
    #1;
    chk("rstscan_rd_data", {24'd0, rd_data}, 0);
    chk("rstscan_cur_addr", {27'd0, cur_addr}, 0);
    chk("rstscan_step", {31'd0, step}, 0);
    chk("rstscan_busy", {31'd0, busy}, 0);
    s_scan = 0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_read("rstscan_manual", $urandom_range(0, DEPTH - 1));
    read_all_check("rstscan_mem");
    scan_run("scan_after_rst", 8);

`ifdef RAM_SCAN_CLEAR_EN
    clear_req = 1'b1;
    wr_en     = 1'b0;
    @(negedge clock);
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("clr_busy_cycles", n, DEPTH);
    @(negedge clock);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    s_scan = 0;
    read_all_check("clr_zero");
`else
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("noclr_busy", {31'd0, busy}, 0);
      @(negedge clock);
    end
    read_all_check("noclr_kept");
`endif
    scan_run("scan_after_clr", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_scan_ctrl.md
RAM_SCAN_CTRL -- requirements
Module: ram_scan_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter TICK_DIV, default 50000000, clock cycles per scan step (>= 2).
REQ-004 SHALL have port: clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: scan_en  in  1  1 = auto-scan mode, 0 = manual mode.
REQ-007 SHALL have port: manual_addr  in  ADDR_W  address used in manual mode.
REQ-008 SHALL have port: wr_data  in  DATA_W  write data.
REQ-009 SHALL have port: wr_en  in  1  write request; honoured in manual mode only.
REQ-010 SHALL have port: clear_req  in  1  request to zero the whole memory.
REQ-011 SHALL have port: rd_data  out  DATA_W  registered read data.
REQ-012 SHALL have port: cur_addr  out  ADDR_W  registered address currently applied to the memory.
REQ-013 SHALL have port: step  out  1  one-cycle pulse on each scan-address advance.
REQ-014 SHALL have port: busy  out  1  high while a clear sweep is in progress.

Function
REQ-015 SHALL implement a three-state FSM: MANUAL, SCAN, CLEAR.
REQ-016 SHALL transition MANUAL->SCAN when scan_en=1 and SCAN->MANUAL when scan_en=0, taking effect on the next edge.
REQ-017 SHALL transition to CLEAR from MANUAL or SCAN when clear_req=1, with priority over scan_en.
REQ-018 SHALL ignore clear_req while in CLEAR.
REQ-019 SHALL register address, wr_data and wr_en in one input stage; cur_addr is the output of that stage.
REQ-020 SHALL write memory[cur_addr] on the edge after the input stage; write latency is 2 edges from the input.
REQ-021 SHALL provide registered read data valid 2 edges after the address is presented.
REQ-022 SHALL use read-first ordering: on a read-during-write to the same address, rd_data returns the old word and the new word one cycle later.
REQ-023 SHALL source the address from manual_addr in MANUAL, from the scan counter in SCAN, and from the clear counter in CLEAR.
REQ-024 SHALL, in SCAN, count tick cycles 0..TICK_DIV-1; at TICK_DIV-1 the tick counter wraps to 0, the scan address increments, and step pulses for 1 cycle.
REQ-025 SHALL wrap the scan address from DEPTH-1 to 0.
REQ-026 SHALL zero the tick counter on every entry to SCAN and retain the scan address across MANUAL periods.
REQ-027 SHALL suppress wr_en in SCAN and CLEAR; a write is never performed in those states.
REQ-028 SHALL, in CLEAR, write 0 to addresses 0..DEPTH-1 at one per cycle, hold busy=1, then exit to SCAN if scan_en=1 and to MANUAL otherwise.
REQ-029 SHALL reset the scan address to 0 on exit from CLEAR.
REQ-030 SHALL keep step=0 outside SCAN.

Reset
REQ-031 SHALL, on reset=0, immediately force state MANUAL, tick, scan and clear counters to 0, rd_data=0, cur_addr=0, step=0 and busy=0.
REQ-032 SHALL leave memory contents unchanged by reset, including reset asserted mid-CLEAR (a partial clear is kept).

Configuration
REQ-033 SHALL compile the CLEAR state and clear counter only when macro RAM_SCAN_CLEAR_EN is defined.
REQ-034 SHALL, without RAM_SCAN_CLEAR_EN, keep the clear_req port, ignore it, and tie busy to 0.

Structure
REQ-035 SHALL place the FSM state encoding and the parameter default constants in shared package ram_scan_pkg.
REQ-036 SHALL implement the tick counter and step pulse in sub-module tick_divider, parametrised by TICK_DIV.

Verification (DATA_W=8, ADDR_W=5, TICK_DIV=4)
REQ-037 SHALL verify manual write/read: manual write 0xA5 to address 3, then read address 3 -> rd_data=0xA5 two edges after the address is applied.
REQ-038 SHALL verify scan stepping: hold scan_en=1 -> step every 4 cycles and cur_addr runs 0,1,..,31,0.
REQ-039 SHALL verify write suppression: wr_en=1 with wr_data=0xFF in SCAN -> all previously written words unchanged.
REQ-040 SHALL verify read-during-write: address 7 holds 0x11, write 0x22 -> rd_data shows 0x11, then 0x22 on the next cycle.
REQ-041 SHALL verify clear: pulse clear_req with the macro defined -> busy high for exactly 32 cycles and all words read 0x00; with the macro undefined -> busy stays 0 and data is retained.
REQ-042 SHALL verify reset mid-scan: assert reset at cur_addr=9 -> outputs go to 0 immediately, state is MANUAL, and memory contents are retained.
